// File: rtl/serial_adder.sv
// Bit-serial adder: latches two WIDTH-bit operands and adds them LSB-first, one bit per clock.
// Optional SERIAL_ADDER_SUB_EN adds a 'sub' input selecting a-b via inverted b and carry-in of 1.
module serial_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res, res_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             ha0_s, ha0_c, ha1_s, ha1_c, fa_c;
  logic [WIDTH-1:0] b_in;
  logic             c_in;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub;
`else
  assign b_in = b;
  assign c_in = 1'b0;
`endif

  // Full-add cell: two half adders plus an OR for the carry.
  always_comb begin
    ha0_s = a_sh[0] ^ b_sh[0];
    ha0_c = a_sh[0] & b_sh[0];
    ha1_s = ha0_s ^ carry;
    ha1_c = ha0_s & carry;
    fa_c  = ha0_c | ha1_c;
  end

  always_comb begin
    res_nxt = '0;
    res_nxt[WIDTH-1] = ha1_s;
    for (int unsigned i = 0; i + 1 < WIDTH; i++) begin
      res_nxt[i] = res[i+1];
    end
  end

  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // sum/cout are only written on the completing edge so partial results never show.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b_in;
            carry <= c_in;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          res   <= res_nxt;
          carry <= fa_c;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum  <= res_nxt;
            cout <= fa_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: a WIDTH=4 and a WIDTH=1 instance checked against directed vectors.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start4 = 1'b0, start1 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy4, done4, cout4, busy1, done1, cout1;
  logic [3:0] sum4;
  logic [0:0] sum1;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub4 = 1'b0;
  logic       sub1 = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] s;
    logic       c;
    int         at;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];
  logic [3:0] held4_s = '0;
  logic       held4_c = 1'b0;
  logic [0:0] held1_s = '0;
  logic       held1_c = 1'b0;

  serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub4),
`endif
    .a(a4), .b(b4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub1),
`endif
    .a(a1), .b(b1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop on done, otherwise sum/cout must hold the last reported result.
  always @(negedge clk) begin
    if (!reset) begin
      if (done4) begin
        if (q4.size() == 0) begin
          chk("w4_unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q4.pop_front();
          chk("w4_sum", int'(sum4), int'(e.s));
          chk("w4_cout", int'(cout4), int'(e.c));
          chk("w4_done_cycle", cyc, e.at);
          held4_s = e.s;
          held4_c = e.c;
        end
      end else begin
        chk("w4_hold", int'({cout4, sum4}), int'({held4_c, held4_s}));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (done1) begin
        if (q1.size() == 0) begin
          chk("w1_unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q1.pop_front();
          chk("w1_sum", int'(sum1), int'(e.s[0]));
          chk("w1_cout", int'(cout1), int'(e.c));
          chk("w1_done_cycle", cyc, e.at);
          held1_s = e.s[0];
          held1_c = e.c;
        end
      end else begin
        chk("w1_hold", int'({cout1, sum1}), int'({held1_c, held1_s}));
      end
    end
  end

  task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic sb,
                     input logic [3:0] es, input logic ec);
    exp_t e;
    a4 = x; b4 = y; start4 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub4 = sb;
`else
    if (sb) chk("sub_requested_without_feature", 1, 0);
`endif
    e.s = es; e.c = ec; e.at = cyc + 1 + 4;
    q4.push_back(e);
    @(posedge clk); #1;
    start4 = 1'b0;
    a4 = ~x; b4 = ~y;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      chk("w4_busy", int'(busy4), (k < 4) ? 1 : 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic op1(input logic x, input logic y, input logic es, input logic ec);
    exp_t e;
    a1 = x; b1 = y; start1 = 1'b1;
    e.s = {3'b000, es}; e.c = ec; e.at = cyc + 1 + 1;
    q1.push_back(e);
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int k = 0; k <= 1; k++) begin
      @(negedge clk);
      chk("w1_busy", int'(busy1), (k < 1) ? 1 : 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_done4();
    int n;
    n = 0;
    while (!done4 && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    chk("w4_done_timeout", int'(done4), 1);
  endtask

  initial begin
    exp_t e;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_busy4", int'(busy4), 0);
    chk("rst_done4", int'(done4), 0);
    chk("rst_sum4", int'(sum4), 0);
    chk("rst_cout4", int'(cout4), 0);
    chk("rst_busy1", int'(busy1), 0);
    chk("rst_sum1", int'(sum1), 0);
    chk("rst_cout1", int'(cout1), 0);

    op4(4'd3, 4'd5, 1'b0, 4'd8, 1'b0);
    op4(4'd15, 4'd1, 1'b0, 4'd0, 1'b1);
    op4(4'd0, 4'd0, 1'b0, 4'd0, 1'b0);
    op4(4'd10, 4'd12, 1'b0, 4'd6, 1'b1);

    // start held high: one operation per IDLE entry, operands disturbed mid-operation
    a4 = 4'd7; b4 = 4'd9; start4 = 1'b1;
    e.s = 4'd0; e.c = 1'b1; e.at = cyc + 1 + 4;  q4.push_back(e);
    e.at = cyc + 1 + 10; q4.push_back(e);
    for (int k = 0; k < 2; k++) begin
      if (k > 0) @(posedge clk);
      @(posedge clk); #1;
      a4 = 4'd3; b4 = 4'd3;
      wait_done4();
      a4 = 4'd7; b4 = 4'd9;
      if (k == 1) start4 = 1'b0;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("hold_start_idle", int'(busy4), 0);

    // reset during the second SHIFT cycle discards the partial result
    a4 = 4'd6; b4 = 4'd6; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    held4_s = '0; held4_c = 1'b0;
    held1_s = '0; held1_c = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_busy", int'(busy4), 0);
    chk("midrst_done", int'(done4), 0);
    chk("midrst_sum", int'(sum4), 0);
    chk("midrst_cout", int'(cout4), 0);
    repeat (8) @(posedge clk);
    #1;
    op4(4'd2, 4'd1, 1'b0, 4'd3, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    op4(4'd5, 4'd3, 1'b1, 4'd2, 1'b1);
    op4(4'd3, 4'd5, 1'b1, 4'd14, 1'b0);
    op4(4'd9, 4'd4, 1'b0, 4'd13, 1'b0);
`endif

    op1(1'b1, 1'b1, 1'b0, 1'b1);
    op1(1'b1, 1'b0, 1'b1, 1'b0);
    op1(1'b0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 20 && (q4.size() != 0 || q1.size() != 0); n++) @(posedge clk);
    #1;
    chk("w4_queue_drained", q4.size(), 0);
    chk("w1_queue_drained", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial adder for the assignment datapath: latches two WIDTH-bit operands, then adds them LSB-first, one bit per clock.
- Each bit uses a full-add cell built internally from two half adders plus an OR gate, with a registered carry between bits.
- The result is assembled in a shift register. A one-cycle done pulse reports the final sum and carry-out.
- Consumes the same operand pairs the half-adder bench drives bit-by-bit, replacing manual per-bit stepping with a clocked sequencer.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin an addition; sampled only in IDLE.
- a  input  WIDTH  operand A; latched on the accepted start.
- b  input  WIDTH  operand B; latched on the accepted start.
- busy  output  1  high while bits are being processed (SHIFT state).
- done  output  1  one-cycle pulse; sum and cout are valid.
- sum  output  WIDTH  result; holds its value until the next accepted start.
- cout  output  1  carry out of the MSB; holds like sum.

Behaviour:
- States: IDLE, SHIFT, DONE. Encoding is free.
- Reset (sampled on a clk edge with reset=1):
  - state goes to IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Internal operand registers, carry and bit counter are cleared.
  - Reset overrides every other input, including mid-operation; a partial result is discarded and never reported.
- IDLE:
  - When start=1 at an edge: a_sh<=a, b_sh<=b, carry<=0, cnt<=0, state<=SHIFT, busy<=1. sum and cout are unchanged.
  - When start=0: remain in IDLE.
- SHIFT (one bit per edge):
  - s = a_sh[0]^b_sh[0]^carry.
  - c = (a_sh[0]&b_sh[0]) | (carry&(a_sh[0]^b_sh[0])).
  - Result register shifts right with s entering at bit WIDTH-1.
  - a_sh and b_sh shift right.
  - carry<=c; cnt<=cnt+1.
  - When cnt==WIDTH-1: state<=DONE, busy<=0, cout<=c, and the completed result is written to sum.
- DONE: done=1 for exactly this one cycle, then state<=IDLE.
- Latency: start sampled at edge N; done high during the cycle after edge N+WIDTH; next start accepted at edge N+WIDTH+2 at the earliest.
- start is ignored while busy=1 or done=1. It is not queued; the operand inputs are not re-sampled.
- sum and cout must not show intermediate values. They change only on the completing edge or on reset.
- Arithmetic: unsigned modulo 2^WIDTH; cout is the true carry out of the MSB.
- Counter width is clog2(WIDTH)+1 bits. For WIDTH=1: one SHIFT cycle, then DONE.
- a and b may change freely after the start edge without affecting the result.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- When defined:
  - Adds port sub (input, 1), sampled together with start.
  - If sub=1 on the accepted start: b is latched inverted (~b) and carry is initialised to 1, so the result is sum=a-b mod 2^WIDTH.
  - cout=1 means no borrow (a>=b); cout=0 means borrow.
  - sub=0 behaves exactly as addition.
- When undefined: no sub port exists; the block is addition only, with identical timing.

Test Plan:
- WIDTH=4, a=3, b=5, pulse start -> busy high for 4 cycles; done pulses at the 5th edge after start; sum=8, cout=0.
- a=15, b=1 -> sum=0, cout=1. Then a=0, b=0 -> sum=0, cout=0; the previous sum=0/cout=1 is held until the completing edge.
- Hold start high continuously with a=7, b=9 -> exactly one operation per IDLE entry (done period WIDTH+2 cycles). Changing a/b mid-operation does not alter the result (sum=0, cout=1).
- Assert reset for 1 cycle at the 2nd SHIFT cycle of a=6, b=6 -> busy=0, done never pulses, sum=0, cout=0. A following start with a=2, b=1 gives sum=3.
- With SERIAL_ADDER_SUB_EN: a=5, b=3, sub=1 -> sum=2, cout=1. Then a=3, b=5, sub=1 -> sum=14, cout=0.
- WIDTH=1 instance: a=1, b=1 -> done at the 2nd edge after start; sum=0, cout=1.
